// File: rtl/frame_scanout_if.sv
// rtl/frame_scanout_if.sv - frame RAM read port between scanout and framebuffer memory
interface frame_scanout_if #(
  parameter int ADDR_W = 20
);
  logic              fbRdEn;
  logic [ADDR_W-1:0] fbRdAddr;
  logic [23:0]       fbRdData;

  modport master (output fbRdEn, output fbRdAddr, input fbRdData);
  modport slave  (input fbRdEn, input fbRdAddr, output fbRdData);
endinterface

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - raster scanout of the displayed framebuffer with vblank buffer swap
module frame_scanout #(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 700,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int ADDR_W        = $clog2(2 * SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  frame_scanout_if.master fb,
  input  logic            frameReady,
  output logic            frameAck,
  output logic            renderBuf,
  output logic [23:0]     pixelRGB,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [15:0]     repeatCount
);

  localparam int H_TOTAL = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(SCREEN_WIDTH);
  localparam logic [HW-1:0] H_SS   = HW'(SCREEN_WIDTH + H_FRONT);
  localparam logic [HW-1:0] H_SE   = HW'(SCREEN_WIDTH + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(SCREEN_HEIGHT);
  localparam logic [VW-1:0] V_SS   = VW'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [VW-1:0] V_SE   = VW'(SCREEN_HEIGHT + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] COL_WORDS   = ADDR_W'(SCREEN_HEIGHT);

  logic [HW-1:0]     h_count;
  logic [VW-1:0]     v_count;
  logic              display_buf;
  logic              active;
  logic              h_sync0;
  logic              v_sync0;
  logic              swap_slot;
  logic [ADDR_W-1:0] addr0;
  logic              s1_de, s1_hs, s1_vs;
  logic              s2_de, s2_hs, s2_vs;

  // Stage 0: decode the raster position; disabled scan looks like permanent blanking.
  always_comb begin
    active    = enable && (h_count < H_ACT) && (v_count < V_ACT);
    h_sync0   = !(enable && (h_count >= H_SS) && (h_count < H_SE));
    v_sync0   = !(enable && (v_count >= V_SS) && (v_count < V_SE));
    swap_slot = enable && (h_count == '0) && (v_count == V_ACT);
    addr0     = (display_buf ? FRAME_WORDS : '0)
              + ADDR_W'(h_count) * COL_WORDS
              + ADDR_W'(v_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (!enable) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Swap only on the first vblank clock, so the frame in flight always reads one buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_buf <= 1'b0;
      frameAck    <= 1'b0;
      repeatCount <= '0;
    end else begin
      frameAck <= 1'b0;
      if (swap_slot) begin
        if (frameReady) begin
          display_buf <= ~display_buf;
          frameAck    <= 1'b1;
          repeatCount <= '0;
        end else if (repeatCount != 16'hFFFF) begin
          repeatCount <= repeatCount + 16'd1;
        end
      end
    end
  end

  assign renderBuf = ~display_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb.fbRdEn   <= 1'b0;
      fb.fbRdAddr <= '0;
      s1_de       <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s2_de       <= 1'b0;
      s2_hs       <= 1'b1;
      s2_vs       <= 1'b1;
      pixelRGB    <= '0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
    end else begin
      fb.fbRdEn <= active;
      if (active) fb.fbRdAddr <= addr0;
      s1_de    <= active;
      s1_hs    <= h_sync0;
      s1_vs    <= v_sync0;
      s2_de    <= s1_de;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      pixelRGB <= s2_de ? fb.fbRdData : 24'd0;
      de       <= s2_de;
      hsync    <= s2_hs;
      vsync    <= s2_vs;
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - scoreboard bench for frame_scanout on a 4x3 raster
module tb_frame_scanout;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 5;
  localparam int HT = 7;
  localparam int VT = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frameReady = 1'b0;
  logic        frameAck;
  logic        renderBuf;
  logic [23:0] pixelRGB;
  logic        hsync, vsync, de;
  logic [15:0] repeatCount;

  frame_scanout_if #(.ADDR_W(AW)) fb ();

  frame_scanout #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
    .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fb(fb),
    .frameReady(frameReady), .frameAck(frameAck), .renderBuf(renderBuf),
    .pixelRGB(pixelRGB), .hsync(hsync), .vsync(vsync), .de(de),
    .repeatCount(repeatCount)
  );

  always #5 clk = ~clk;

  logic [23:0] ram [0:2*W*H-1];
  initial begin
    for (int i = 0; i < 2*W*H; i++) ram[i] = 24'(i);
    fb.fbRdData = '0;
  end
  always @(posedge clk) if (fb.fbRdEn) fb.fbRdData <= ram[fb.fbRdAddr];

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } exp_t;

  exp_t    exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      mh, mv, mbuf, cyc;
  int      rep;
  logic    exp_en1, exp_ack;
  logic [AW-1:0] exp_addr1;
  logic    vs_prev, vs_valid;
  int      vs_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'd0});
    mh = 0; mv = 0; mbuf = 0; rep = 0;
    exp_en1 = 1'b0; exp_addr1 = '0; exp_ack = 1'b0;
    vs_prev = 1'b1; vs_valid = 1'b0; vs_last = 0;
  endtask

  task automatic reset_check();
    chk("rst_fbRdEn", fb.fbRdEn, 0);
    chk("rst_fbRdAddr", fb.fbRdAddr, 0);
    chk("rst_frameAck", frameAck, 0);
    chk("rst_renderBuf", renderBuf, 1);
    chk("rst_pixelRGB", pixelRGB, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_repeatCount", repeatCount, 0);
  endtask

  // One clock: check what the DUT shows now, then advance the reference raster.
  task automatic step();
    exp_t e;
    logic act;
    int   a;
    @(negedge clk);
    chk("fbRdEn", fb.fbRdEn, exp_en1);
    chk("fbRdAddr", fb.fbRdAddr, exp_addr1);
    e = exp_q.pop_front();
    chk("de", de, e.de);
    chk("hsync", hsync, e.hs);
    chk("vsync", vsync, e.vs);
    chk("pixelRGB", pixelRGB, e.rgb);
    chk("frameAck", frameAck, exp_ack);
    chk("renderBuf", renderBuf, (mbuf == 0));
    chk("repeatCount", repeatCount, rep);
    if (vsync == 1'b0 && vs_prev == 1'b1) begin
      if (vs_valid) chk("vsync_period", cyc - vs_last, 42);
      vs_last  = cyc;
      vs_valid = 1'b1;
    end
    vs_prev = vsync;
    if (!enable) vs_valid = 1'b0;

    act = enable && mh < W && mv < H;
    a   = mbuf * W * H + mh * H + mv;
    exp_en1 = act;
    if (act) exp_addr1 = AW'(a);
    exp_q.push_back('{de: act,
                      hs: !(enable && mh == W + 1),
                      vs: !(enable && mv == H + 1),
                      rgb: act ? ram[a] : 24'd0});
    exp_ack = 1'b0;
    if (enable && mh == 0 && mv == H) begin
      if (frameReady) begin
        mbuf    = 1 - mbuf;
        exp_ack = 1'b1;
        rep     = 0;
      end else if (rep != 16'hFFFF) begin
        rep = rep + 1;
      end
    end
    if (!enable) begin
      mh = 0; mv = 0;
    end else if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_check();
    rst_n = 1'b1;
    run(3);

    enable = 1'b1;
    run(126);
    chk("repeat_after_3_frames", repeatCount, 3);

    frameReady = 1'b1;
    run(22);
    chk("swap_ack", frameAck, 1);
    chk("swap_renderBuf", renderBuf, 0);
    frameReady = 1'b0;
    run(22);

    frameReady = 1'b1;
    run(5);
    frameReady = 1'b0;
    run(44);

    enable = 1'b0;
    run(6);
    enable = 1'b1;
    run(9);

    rst_n = 1'b0;
    #1;
    reset_check();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
